// File: rtl/mem_pkg.sv
// Shared types and default geometry for the parameterised data memory.
package mem_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 8;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } mem_state_e;

endpackage

// File: rtl/ram_array.sv
// Single write port, single registered read port storage array.
// A read and a write to the same address in one cycle return the old word.
module ram_array #(
   parameter int WORD_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [2**ADDR_W];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/param_data_memory.sv
// Data memory with power-on/requested full-array clear and write-first read bypass.
// Optional MEM_PARITY_EN adds an even-parity bit per word and a parity_err output.
//
// state | meaning
// CLEAR | zeroing one word per cycle from address 0 upward; busy=1, requests ignored
// IDLE  | servicing reads/writes; clear_req starts a new clear sequence
module param_data_memory
   import mem_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_write_tb,
   input  logic              clear_req,
   input  logic [ADDR_W-1:0] access_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              read_valid,
   output logic              busy
`ifdef MEM_PARITY_EN
   ,
   output logic              parity_err
`endif
);

`ifdef MEM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              rd_vld_q, rd_vld_d;
   logic              byp_q, byp_d;
   logic [DATA_W-1:0] byp_data_q, byp_data_d;

   logic              wr_req;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_waddr;
   logic [WORD_W-1:0] ram_wdata, ram_rdata, wr_word;
   logic [DATA_W-1:0] rd_mux;

   assign wr_req = mem_write | mem_write_tb;

`ifdef MEM_PARITY_EN
   assign wr_word = {^write_data, write_data};
`else
   assign wr_word = write_data;
`endif

   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      rd_vld_d   = 1'b0;
      byp_d      = 1'b0;
      byp_data_d = byp_data_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      ram_waddr  = access_addr;
      ram_wdata  = wr_word;
      case (state_q)
         CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr_q;
            ram_wdata = '0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) state_d = IDLE;
         end
         IDLE: begin
            // A clear request drops a coincident write but lets a read finish.
            ram_re     = mem_read;
            rd_vld_d   = mem_read;
            ram_we     = wr_req & ~clear_req;
            byp_d      = mem_read & ram_we;
            byp_data_d = write_data;
            if (clear_req) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         clr_ptr_q  <= '0;
         rd_vld_q   <= 1'b0;
         byp_q      <= 1'b0;
         byp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         rd_vld_q   <= rd_vld_d;
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
      end
   end

   ram_array #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (access_addr),
      .rdata_o (ram_rdata)
   );

   assign rd_mux     = byp_q ? byp_data_q : ram_rdata[DATA_W-1:0];
   assign read_data  = rd_vld_q ? rd_mux : '0;
   assign read_valid = rd_vld_q;
   assign busy       = (state_q == CLEAR);

`ifdef MEM_PARITY_EN
   // Bypassed data was just encoded from write_data, so it cannot carry an error.
   assign parity_err = rd_vld_q & ~byp_q & (^ram_rdata);
`endif

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: reads push expectations, a monitor pops on read_valid.
module tb_param_data_memory;

   localparam int DW = 8;
   localparam int AW = 8;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
      logic          perr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_read, mem_write, mem_write_tb, clear_req;
   logic [AW-1:0] access_addr;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data;
   logic          read_valid, busy;
`ifdef MEM_PARITY_EN
   logic          parity_err;
`endif

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   param_data_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_write_tb (mem_write_tb),
      .clear_req    (clear_req),
      .access_addr  (access_addr),
      .write_data   (write_data),
      .read_data    (read_data),
      .read_valid   (read_valid),
      .busy         (busy)
`ifdef MEM_PARITY_EN
      ,
      .parity_err   (parity_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: checks every presented read result against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (read_valid === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid data=%h cyc=%0d", read_data, cyc);
         end else begin
            e = sb_q.pop_front();
            if (read_data !== e.data || cyc != e.due) begin
               bad++;
               $display("FAIL read_result got=%h@%0d want=%h@%0d", read_data, cyc, e.data, e.due);
            end
`ifdef MEM_PARITY_EN
            total++;
            if (parity_err !== e.perr) begin
               bad++;
               $display("FAIL parity_err got=%b want=%b", parity_err, e.perr);
            end
`endif
         end
      end else begin
         total++;
         if (read_data !== '0) begin
            bad++;
            $display("FAIL idle_read_data got=%h want=00 cyc=%0d", read_data, cyc);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic perr = 1'b0);
      access_addr = a;
      mem_read    = 1'b1;
      sb_q.push_back('{data: exp, due: cyc + 1, perr: perr});
      @(negedge clk);
      mem_read    = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit via_tb);
      access_addr  = a;
      write_data   = d;
      mem_write    = !via_tb;
      mem_write_tb = via_tb;
      @(negedge clk);
      mem_write    = 1'b0;
      mem_write_tb = 1'b0;
   endtask

   // Counts consecutive busy cycles starting at the current negedge; inputs are
   // hammered meanwhile to show they are ignored.
   task automatic busy_len(input string nm);
      int n = 0;
      mem_read     = 1'b1;
      mem_write    = 1'b1;
      mem_write_tb = 1'b1;
      clear_req    = 1'b1;
      access_addr  = 8'h7F;
      write_data   = 8'hFF;
      while (busy === 1'b1 && n < 1000) begin
         n++;
         @(negedge clk);
      end
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_write_tb = 1'b0;
      clear_req    = 1'b0;
      chk(nm, n, 256);
   endtask

   initial begin
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_write_tb = 1'b0;
      clear_req = 1'b0; access_addr = '0; write_data = '0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 1);
      chk("rst_valid", int'(read_valid), 0);
      chk("rst_data", int'(read_data), 0);
      rst_n = 1'b1;
      busy_len("boot_clear_len");

      // post-clear contents are zero; hammered write of FF @7F must not have landed
      rd(8'h7F, 8'h00);
      rd(8'h00, 8'h00);
      rd(8'hFF, 8'h00);

      wr(8'h10, 8'hA5, 0);
      rd(8'h10, 8'hA5);
      wr(8'h11, 8'h5A, 1);
      rd(8'h11, 8'h5A);

      // same-cycle write and read: write-first bypass
      access_addr = 8'h22; write_data = 8'h3C; mem_write = 1'b1; mem_read = 1'b1;
      sb_q.push_back('{data: 8'h3C, due: cyc + 1, perr: 1'b0});
      @(negedge clk);
      mem_write = 1'b0; mem_read = 1'b0;

      // back-to-back reads
      rd(8'h10, 8'hA5);
      rd(8'h11, 8'h5A);
      rd(8'h22, 8'h3C);
      wr(8'hFF, 8'hC3, 1);
      rd(8'hFF, 8'hC3);

      // clear with coincident read: read completes first
      wr(8'h30, 8'h77, 0);
      access_addr = 8'h30; mem_read = 1'b1; clear_req = 1'b1;
      sb_q.push_back('{data: 8'h77, due: cyc + 1, perr: 1'b0});
      @(negedge clk);
      mem_read = 1'b0; clear_req = 1'b0;
      busy_len("clear_rd_len");
      rd(8'h30, 8'h00);

      // clear with coincident write: write dropped
      wr(8'h05, 8'h11, 0);
      access_addr = 8'h06; write_data = 8'h99; mem_write = 1'b1; clear_req = 1'b1;
      @(negedge clk);
      mem_write = 1'b0; clear_req = 1'b0;
      chk("clear_wr_busy", int'(busy), 1);
      busy_len("clear_wr_len");
      rd(8'h05, 8'h00);
      rd(8'h06, 8'h00);

      // reset at clear cycle 100 restarts the full sequence
      wr(8'hC8, 8'hEE, 0);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      busy_len("rst_mid_clear_len");
      rd(8'hC8, 8'h00);
      rd(8'h7F, 8'h00);

`ifdef MEM_PARITY_EN
      wr(8'h40, 8'h0F, 0);
      rd(8'h40, 8'h0F, 1'b0);
      dut.u_ram.mem_q[8'h40] = dut.u_ram.mem_q[8'h40] ^ 9'h001;
      rd(8'h40, 8'h0E, 1'b1);
`endif

      begin
         int w = 0;
         while (sb_q.size() != 0 && w < 20) begin
            w++;
            @(negedge clk);
         end
         chk("sb_drained", sb_q.size(), 0);
      end
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 mem_read  input  1  read request, sampled at rising edge.
REQ-006 mem_write  input  1  write request from datapath.
REQ-007 mem_write_tb  input  1  write request from testbench/loader; ORed with mem_write.
REQ-008 clear_req  input  1  one-cycle pulse requesting full-array zeroing.
REQ-009 access_addr  input  ADDR_W  shared read/write word address.
REQ-010 write_data  input  DATA_W  write data.
REQ-011 read_data  output  DATA_W  registered read data; 0 whenever read_valid=0.
REQ-012 read_valid  output  1  one-cycle pulse, read_data valid this cycle.
REQ-013 busy  output  1  high while clear sequence runs; requests ignored.

Function
REQ-014 FSM states: CLEAR, IDLE; CLEAR->IDLE after last word zeroed, IDLE->CLEAR on clear_req.
REQ-015 CLEAR: zero one word per cycle, address 0 to DEPTH-1 ascending; exactly DEPTH cycles; busy=1 throughout.
REQ-016 In CLEAR, mem_read/mem_write/mem_write_tb/clear_req ignored; read_valid stays 0.
REQ-017 IDLE write: (mem_write|mem_write_tb)=1 at edge -> ram[access_addr]<=write_data that edge.
REQ-018 IDLE read: mem_read=1 at edge N -> read_data=ram[access_addr], read_valid=1 during cycle N+1; latency 1.
REQ-019 Read and write same cycle: both performed; read returns new write_data (write-first bypass).
REQ-020 Back-to-back reads: one result per cycle, read_valid continuously high.
REQ-021 clear_req with write in same IDLE cycle: clear wins, write dropped; busy=1 next cycle.
REQ-022 clear_req with read in same IDLE cycle: read completes (read_valid next cycle), then clear proceeds.
REQ-023 Address is exactly ADDR_W bits; no out-of-range case; no wrap logic.

Reset
REQ-024 rst_n=0 at edge: FSM->CLEAR, clear pointer=0, read_data=0, read_valid=0, busy=1 next cycle.
REQ-025 Reset during CLEAR restarts clear from address 0.
REQ-026 After reset release, array reads all-zero once busy falls; no X contents observable.

Configuration
REQ-027 Macro MEM_PARITY_EN: when defined, each word stores one extra even-parity bit computed on write; CLEAR writes parity 0.
REQ-028 With MEM_PARITY_EN: output parity_err (1 bit) asserts with read_valid when stored parity mismatches recomputed parity; 0 otherwise and in reset.
REQ-029 Without MEM_PARITY_EN: no parity storage, no parity_err port; all other behaviour identical.

Structure
REQ-030 Shared package mem_pkg: FSM state enum {CLEAR, IDLE}, default DATA_W/ADDR_W constants.
REQ-031 Storage in sub-module ram_array (single write port, single synchronous read port, parametrised width incl. optional parity bit); FSM, bypass, clear counter in top.

Verification
REQ-032 Reset 1 cycle -> busy=1 for 256 cycles (defaults), then busy=0; read addr 0x7F -> read_data=0x00, read_valid=1 next cycle.
REQ-033 Write 0xA5 @0x10, then read 0x10 -> read_data=0xA5 one cycle after request.
REQ-034 Same-cycle write 0x3C and read @0x22 -> read_data=0x3C next cycle.
REQ-035 Write 0x11 @0x05, pulse clear_req with write 0x99 @0x06 -> after clear, 0x05 and 0x06 read 0x00.
REQ-036 Assert rst_n=0 at clear cycle 100 -> busy stays 1 for full 256 cycles after release.
REQ-037 MEM_PARITY_EN: force-flip stored bit of word @0x40 holding 0x0F -> read gives parity_err=1 with read_valid.
